interrupt_controller: RTL and testbench

Sequences the pipeline through hardware interrupt entry and RTI return. It freezes fetch, drains in-flight instructions, and pushes the return PC and flags. It then redirects fetch to the interrupt vector, and performs the reverse pop on RTI. It sits beside the fetch mux and the memory stage, replacing the tied-off `interrupt`, `int_mem_selector1` and `int_mem_selector2` controls with real sequencing.

---
 rtl/interrupt_pkg.sv | 28 ++
 rtl/int_request_latch.sv | 35 +++
 rtl/interrupt_controller.sv | 155 +++++++++++++++
 tb/tb_interrupt_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared types for the interrupt entry/RTI sequencer.
// State encoding, memory write-data selector codes, default vector.
package interrupt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLAGS,
    VECTOR,
    POP_FLAGS,
    POP_LO,
    POP_HI,
    RESUME
  } state_t;

  typedef enum logic [1:0] {
    SEL_NORMAL = 2'b00,
    SEL_PC_LO  = 2'b01,
    SEL_PC_HI  = 2'b10,
    SEL_FLAGS  = 2'b11
  } sel_t;

  localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0010;
  localparam int DEFAULT_DRAIN_CYCLES = 3;

endpackage

// File: rtl/int_request_latch.sv
// Pending interrupt request flop with busy/ISR masking.
// INT_PENDING_EN: hold one request raised while busy or in an ISR.
module int_request_latch (
  input  logic clk,
  input  logic reset,
  input  logic interrupt,
  input  logic busy,
  input  logic in_isr,
  input  logic clear,
  output logic pending
);

  logic req;
  logic accept;

`ifdef INT_PENDING_EN
  assign accept = interrupt;
`else
  assign accept = interrupt & ~busy & ~in_isr;
`endif

  // A fresh pulse is visible this cycle so IDLE can enter DRAIN at once.
  assign pending = req | accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req <= 1'b0;
    end else if (clear) begin
      req <= 1'b0;
    end else if (accept) begin
      req <= 1'b1;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt entry (drain, push PC/flags, vector) and RTI pop sequencer.
// Build with INT_PENDING_EN to queue interrupts raised during an ISR.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int          DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
  parameter logic [31:0] VECTOR_ADDR  = DEFAULT_VECTOR_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  input  logic        rti,
  input  logic [31:0] pc_in,
  input  logic [3:0]  flags_in,
  input  logic [15:0] mem_read_data,
  output logic        int_stall,
  output logic        int_flush,
  output logic        int_mem_selector1,
  output logic        int_mem_selector2,
  output logic        int_push,
  output logic        int_pop,
  output logic        int_pc_load,
  output logic [31:0] int_pc_out,
  output logic        flags_restore,
  output logic [3:0]  flags_out,
  output logic [31:0] saved_pc,
  output logic [3:0]  saved_flags,
  output logic        in_isr,
  output logic        busy
);

  localparam int CW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [15:0]   pc_lo;
  logic [15:0]   pc_hi;
  logic          pending;
  logic          enter_drain;
  sel_t          sel;

  assign enter_drain = (state_q == IDLE) && (state_d == DRAIN);

  int_request_latch u_req (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .busy      (busy),
    .in_isr    (in_isr),
    .clear     (enter_drain),
    .pending   (pending)
  );

  assign int_mem_selector1 = sel[0];
  assign int_mem_selector2 = sel[1];

  always_comb begin
    state_d       = state_q;
    int_stall     = 1'b0;
    int_flush     = 1'b0;
    int_push      = 1'b0;
    int_pop       = 1'b0;
    int_pc_load   = 1'b0;
    int_pc_out    = '0;
    flags_restore = 1'b0;
    sel           = SEL_NORMAL;
    busy          = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (rti) begin
          state_d = POP_FLAGS;
        end else if (pending && !in_isr) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        if (cnt_q == '0) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        int_push  = 1'b1;
        sel       = SEL_PC_HI;
        state_d   = PUSH_LO;
      end
      PUSH_LO: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        int_push  = 1'b1;
        sel       = SEL_PC_LO;
        state_d   = PUSH_FLAGS;
      end
      PUSH_FLAGS: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        int_push  = 1'b1;
        sel       = SEL_FLAGS;
        state_d   = VECTOR;
      end
      VECTOR: begin
        int_pc_load = 1'b1;
        int_pc_out  = VECTOR_ADDR;
        state_d     = IDLE;
      end
      POP_FLAGS, POP_LO, POP_HI: begin
        int_stall = 1'b1;
        int_flush = 1'b1;
        int_pop   = 1'b1;
        if (state_q == POP_FLAGS) state_d = POP_LO;
        else if (state_q == POP_LO) state_d = POP_HI;
        else state_d = RESUME;
      end
      RESUME: begin
        int_pc_load   = 1'b1;
        int_pc_out    = {pc_hi, pc_lo};
        flags_restore = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      saved_pc    <= '0;
      saved_flags <= '0;
      flags_out   <= '0;
      pc_lo       <= '0;
      pc_hi       <= '0;
      in_isr      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_drain) begin
        saved_pc <= pc_in;
        cnt_q    <= CW'(DRAIN_CYCLES - 1);
      end else if (state_q == DRAIN && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Last drain cycle wins: flags settle once older ops retire.
      if (state_q == DRAIN) saved_flags <= flags_in;
      if (state_q == POP_FLAGS) flags_out <= mem_read_data[3:0];
      if (state_q == POP_LO) pc_lo <= mem_read_data;
      if (state_q == POP_HI) pc_hi <= mem_read_data;
      if (state_q == PUSH_FLAGS) in_isr <= 1'b1;
      if (state_q == POP_HI) in_isr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: phase-timed reference model plus directed cases.
// Honors INT_PENDING_EN the same way as the design.
module tb_interrupt_controller;

  localparam int D = 3;
  localparam logic [31:0] VEC = 32'h0000_0010;
`ifdef INT_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        interrupt = 1'b0;
  logic        rti = 1'b0;
  logic [31:0] pc_in = '0;
  logic [3:0]  flags_in = '0;
  logic [15:0] mem_read_data = '0;
  logic        int_stall, int_flush;
  logic        int_mem_selector1, int_mem_selector2;
  logic        int_push, int_pop, int_pc_load;
  logic [31:0] int_pc_out;
  logic        flags_restore;
  logic [3:0]  flags_out;
  logic [31:0] saved_pc;
  logic [3:0]  saved_flags;
  logic        in_isr, busy;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 entry, 2 return; k = cycle index in sequence.
  int          mode = 0;
  int          k = 0;
  bit          m_isr = 0;
  bit          m_req = 0;
  logic [31:0] m_spc = '0;
  logic [3:0]  m_sflags = '0;
  logic [3:0]  m_fout = '0;
  logic [15:0] m_plo = '0;
  logic [15:0] m_phi = '0;

  interrupt_controller #(
    .DRAIN_CYCLES (D),
    .VECTOR_ADDR  (VEC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .interrupt         (interrupt),
    .rti               (rti),
    .pc_in             (pc_in),
    .flags_in          (flags_in),
    .mem_read_data     (mem_read_data),
    .int_stall         (int_stall),
    .int_flush         (int_flush),
    .int_mem_selector1 (int_mem_selector1),
    .int_mem_selector2 (int_mem_selector2),
    .int_push          (int_push),
    .int_pop           (int_pop),
    .int_pc_load       (int_pc_load),
    .int_pc_out        (int_pc_out),
    .flags_restore     (flags_restore),
    .flags_out         (flags_out),
    .saved_pc          (saved_pc),
    .saved_flags       (saved_flags),
    .in_isr            (in_isr),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mode = 0; k = 0; m_isr = 0; m_req = 0;
    m_spc = '0; m_sflags = '0; m_fout = '0;
    m_plo = '0; m_phi = '0;
  endtask

  task automatic model_step();
    bit bsy, acc, pend;
    if (reset) begin
      model_reset();
    end else begin
      bsy  = (mode != 0);
      acc  = PEND ? interrupt : (interrupt && !bsy && !m_isr);
      pend = m_req || acc;
      m_req = pend;
      if (mode == 0) begin
        if (rti) begin
          mode = 2; k = 1;
        end else if (pend && !m_isr) begin
          mode = 1; k = 1; m_spc = pc_in; m_req = 0;
        end
      end else if (mode == 1) begin
        if (k <= D) m_sflags = flags_in;
        if (k == D + 4) mode = 0;
        else begin
          k++;
          if (k == D + 4) m_isr = 1;
        end
      end else begin
        if (k == 1) m_fout = mem_read_data[3:0];
        if (k == 2) m_plo = mem_read_data;
        if (k == 3) m_phi = mem_read_data;
        if (k == 4) mode = 0;
        else begin
          k++;
          if (k == 4) m_isr = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin : cmp
    logic e_stall, e_push, e_pop, e_load, e_rest;
    logic [1:0]  e_sel;
    logic [31:0] e_pco;
    e_stall = 0; e_push = 0; e_pop = 0; e_load = 0; e_rest = 0;
    e_sel = 2'b00; e_pco = '0;
    if (mode == 1) begin
      if (k <= D) e_stall = 1;
      else if (k <= D + 3) begin
        e_stall = 1; e_push = 1;
        e_sel = (k == D + 1) ? 2'b10 : (k == D + 2) ? 2'b01 : 2'b11;
      end else begin
        e_load = 1; e_pco = VEC;
      end
    end else if (mode == 2) begin
      if (k <= 3) begin
        e_stall = 1; e_pop = 1;
      end else begin
        e_load = 1; e_rest = 1; e_pco = {m_phi, m_plo};
      end
    end
    chk("int_stall", 32'(int_stall), 32'(e_stall));
    chk("int_flush", 32'(int_flush), 32'(e_stall));
    chk("int_push", 32'(int_push), 32'(e_push));
    chk("int_pop", 32'(int_pop), 32'(e_pop));
    chk("int_pc_load", 32'(int_pc_load), 32'(e_load));
    chk("int_pc_out", int_pc_out, e_pco);
    chk("selectors", 32'({int_mem_selector2, int_mem_selector1}),
        32'(e_sel));
    chk("flags_restore", 32'(flags_restore), 32'(e_rest));
    chk("flags_out", 32'(flags_out), 32'(m_fout));
    chk("saved_pc", saved_pc, m_spc);
    chk("saved_flags", 32'(saved_flags), 32'(m_sflags));
    chk("in_isr", 32'(in_isr), 32'(m_isr));
    chk("busy", 32'(busy), 32'(mode != 0));
    chk("one_ctl", 32'($countones({int_push, int_pop, int_pc_load}) <= 1),
        32'd1);
  end

  task automatic cyc(input logic i, input logic r, input logic [31:0] p,
                     input logic [3:0] f, input logic [15:0] m);
    interrupt = i; rti = r; pc_in = p; flags_in = f; mem_read_data = m;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 4'h0, 16'h0);
  endtask

  task automatic enter();
    cyc(1, 0, 32'h0000_1234, 4'h3, 16'h0);
    idle(D + 3);
  endtask

  task automatic do_rti();
    cyc(0, 1, 32'h0, 4'h0, 16'h0);
    cyc(0, 0, 32'h0, 4'h0, 16'h000a);
    cyc(0, 0, 32'h0, 4'h0, 16'h1234);
    cyc(0, 0, 32'h0, 4'h0, 16'h0000);
  endtask

  task automatic settle();
    idle(D + 6);
    if (m_isr) begin
      do_rti();
      idle(D + 6);
    end
    if (m_isr) begin
      do_rti();
      idle(2);
    end
  endtask

  initial begin
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    #1;
    chk("rst_stall", 32'(int_stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc_out", int_pc_out, 32'd0);
    reset = 1'b0;
    idle(2);

    // Idle interrupt entry
    cyc(1, 0, 32'h0000_0040, 4'b0101, 16'h0);
    chk("e1_stall", 32'(int_stall), 32'd1);
    cyc(0, 0, 32'h0000_0040, 4'b0101, 16'h0);
    cyc(0, 0, 32'h0000_0040, 4'b0101, 16'h0);
    cyc(0, 0, 32'h0000_0040, 4'b0101, 16'h0);
    chk("e4_sel", 32'({int_mem_selector2, int_mem_selector1}), 32'd2);
    chk("e4_saved_pc", saved_pc, 32'h0000_0040);
    cyc(0, 0, 32'h0000_0040, 4'b0101, 16'h0);
    chk("e5_sel", 32'({int_mem_selector2, int_mem_selector1}), 32'd1);
    cyc(0, 0, 32'h0000_0040, 4'b0101, 16'h0);
    chk("e6_sel", 32'({int_mem_selector2, int_mem_selector1}), 32'd3);
    chk("e6_saved_flags", 32'(saved_flags), 32'h5);
    cyc(0, 0, 32'h0000_0040, 4'b0101, 16'h0);
    chk("e7_pc_load", 32'(int_pc_load), 32'd1);
    chk("e7_pc_out", int_pc_out, 32'h10);
    chk("e7_in_isr", 32'(in_isr), 32'd1);
    chk("e7_stall", 32'(int_stall), 32'd0);
    idle(1);

    // RTI after entry
    cyc(0, 1, 32'h0, 4'h0, 16'h0);
    cyc(0, 0, 32'h0, 4'h0, 16'h0005);
    cyc(0, 0, 32'h0, 4'h0, 16'h0040);
    cyc(0, 0, 32'h0, 4'h0, 16'h0000);
    chk("r4_pc_out", int_pc_out, 32'h0000_0040);
    chk("r4_restore", 32'(flags_restore), 32'd1);
    chk("r4_flags_out", 32'(flags_out), 32'b0101);
    chk("r4_in_isr", 32'(in_isr), 32'd0);
    idle(2);

    // Interrupt during ISR
    enter();
    idle(1);
    cyc(1, 0, 32'h0, 4'h0, 16'h0);
    idle(2);
    do_rti();
    idle(1);
    chk("nest_idle_busy", 32'(busy), 32'd0);
    idle(1);
    chk("nest_entry", 32'(int_stall), 32'(PEND));
    settle();

    // Simultaneous interrupt and rti while in ISR
    enter();
    idle(1);
    cyc(1, 1, 32'h0, 4'h0, 16'h0);
    chk("sim_pop", 32'(int_pop), 32'd1);
    cyc(0, 0, 32'h0, 4'h0, 16'h0007);
    cyc(0, 0, 32'h0, 4'h0, 16'h5678);
    cyc(0, 0, 32'h0, 4'h0, 16'h0000);
    chk("sim_resume", 32'(int_pc_load), 32'd1);
    idle(2);
    chk("sim_drain", 32'(int_stall), 32'(PEND));
    settle();

    // Reset mid PUSH_LO, with a request raised during drain
    cyc(1, 0, 32'h0000_0abc, 4'h9, 16'h0);
    cyc(1, 0, 32'h0, 4'h9, 16'h0);
    idle(D);
    chk("pre_rst_sel", 32'({int_mem_selector2, int_mem_selector1}), 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_push", 32'(int_push), 32'd0);
    chk("rst_stall2", 32'(int_stall), 32'd0);
    chk("rst_saved_pc", saved_pc, 32'd0);
    chk("rst_in_isr", 32'(in_isr), 32'd0);
    @(posedge clk);
    model_step();
    #1;
    reset = 1'b0;
    idle(2);
    chk("rst_req_clr", 32'(busy), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0;
      end
      cyc($urandom_range(0, 12) == 0, $urandom_range(0, 9) == 0,
          $urandom, 4'($urandom), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
